// File: rtl/game_tick_pkg.sv
// Shared types for the game tick scheduler: configuration opcodes and
// per-channel state encoding.
package game_tick_pkg;

    typedef enum logic [1:0] {
        CFG_NOP    = 2'b00,
        CFG_LOAD   = 2'b01,
        CFG_STOP   = 2'b10,
        CFG_RESUME = 2'b11
    } cfg_op_e;

    typedef enum logic [1:0] {
        CH_IDLE = 2'b00,
        CH_RUN  = 2'b01,
        CH_DONE = 2'b10
    } ch_state_e;

endpackage

// File: rtl/tick_scheduler_channel.sv
// One tick channel: down-counter clocked by the shared base strobe, with
// free-run / one-shot modes and stop/resume control. A config strobe on this
// channel takes priority over the base-strobe update in the same cycle.
module tick_channel
    import game_tick_pkg::*;
#(
    parameter int CNT_W          = 10,
    parameter int DEFAULT_PERIOD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             base,
    input  logic             cfg_sel,
    input  cfg_op_e          cfg_op,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_oneshot,
    output logic             tick,
    output logic             running,
    output logic             done
);

    ch_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic             oneshot;

    // Channel state, counter and tick pulse; config ops win over the base update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CH_RUN;
            cnt     <= CNT_W'(DEFAULT_PERIOD);
            per     <= CNT_W'(DEFAULT_PERIOD);
            oneshot <= 1'b0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (cfg_sel) begin
                case (cfg_op)
                    CFG_LOAD: begin
                        per     <= cfg_period;
                        cnt     <= cfg_period;
                        oneshot <= cfg_oneshot;
                        state   <= CH_RUN;
                    end
                    CFG_STOP: begin
                        if (state == CH_RUN) begin
                            state <= CH_IDLE;
                        end
                    end
                    CFG_RESUME: begin
                        if (state == CH_IDLE) begin
                            state <= CH_RUN;
                        end else if (state == CH_DONE) begin
                            state <= CH_RUN;
                            cnt   <= per;
                        end
                    end
                    default: begin
                    end
                endcase
            end else if (base && (state == CH_RUN)) begin
                if (cnt == '0) begin
                    tick <= 1'b1;
                    if (oneshot) begin
                        state <= CH_DONE;
                    end else begin
                        cnt <= per;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    assign running = (state == CH_RUN);
    assign done    = (state == CH_DONE);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel game tick generator: a shared prescaler produces the base
// strobe, pause/step gate it, and cfg_ch selects which channel a config op hits.
module tick_scheduler
    import game_tick_pkg::*;
#(
    parameter int NUM_CH         = 3,
    parameter int PRE_W          = 2,
    parameter int CNT_W          = 10,
    parameter int DEFAULT_PERIOD = 0,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause,
    input  logic              step,
    input  logic [1:0]        cfg_op,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running,
    output logic [NUM_CH-1:0] done
);

    logic [PRE_W-1:0]  pre_cnt;
    logic              frozen;
    logic              base;
    logic              cfg_valid;
    cfg_op_e           op;
    logic [NUM_CH-1:0] sel;

    // A step pulse while paused lets exactly one cycle through
    assign frozen    = pause & ~step;
    assign base      = (&pre_cnt) & ~frozen;
    assign op        = cfg_op_e'(cfg_op);
    assign cfg_valid = (op != CFG_NOP) && (int'(cfg_ch) < NUM_CH);

    // Shared prescaler, held whenever the scheduler is frozen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (!frozen) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i] = cfg_valid && (cfg_ch == CH_W'(i));

        tick_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .base        (base),
            .cfg_sel     (sel[i]),
            .cfg_op      (op),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .tick        (tick[i]),
            .running     (running[i]),
            .done        (done[i])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with NUM_CH=3, PRE_W=2, CNT_W=4,
// DEFAULT_PERIOD=1. Edges are numbered from 1 after reset release; outputs are
// sampled 1 time unit after each rising edge. Because the prescaler is shared,
// channel updates only ever land on edges that are multiples of 4.
module tb_tick_scheduler;
    import game_tick_pkg::*;

    localparam int NUM_CH = 3;
    localparam int PRE_W  = 2;
    localparam int CNT_W  = 4;
    localparam int DEFP   = 1;

    logic              clk;
    logic              reset;
    logic              pause;
    logic              step;
    logic [1:0]        cfg_op;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] done;

    int vectors;
    int miscompares;
    int edge_n;
    int pulses [NUM_CH];

    tick_scheduler #(
        .NUM_CH         (NUM_CH),
        .PRE_W          (PRE_W),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .step        (step),
        .cfg_op      (cfg_op),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
        .tick        (tick),
        .running     (running),
        .done        (done)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    // Drive the config port for the next rising edge
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] ch,
                                 input logic [CNT_W-1:0] period, input logic oneshot);
        cfg_op      = op;
        cfg_ch      = ch;
        cfg_period  = period;
        cfg_oneshot = oneshot;
    endtask

    // Advance one edge and accumulate tick pulses per channel
    task automatic clkCycle();
        @(posedge clk);
        #1;
        edge_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i]) pulses[i]++;
        end
    endtask

    task automatic runTo(input int n);
        while (edge_n < n) clkCycle();
    endtask

    task automatic clearPulses();
        for (int i = 0; i < NUM_CH; i++) pulses[i] = 0;
    endtask

    // Apply a config op so that it is sampled on edge n, then return to NOP
    task automatic cfgAt(input int n, input logic [1:0] op, input logic [1:0] ch,
                         input logic [CNT_W-1:0] period, input logic oneshot);
        runTo(n - 1);
        applyStimulus(op, ch, period, oneshot);
        clkCycle();
        applyStimulus(2'b00, 2'd0, '0, 1'b0);
    endtask

    // Hold reset over a couple of edges and release just after a rising edge
    task automatic doReset();
        reset = 1'b1;
        pause = 1'b0;
        step  = 1'b0;
        applyStimulus(2'b00, 2'd0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
        clearPulses();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        edge_n      = 0;
        clearPulses();

        // Free-run after reset: all channels tick together on edges 8, 16, 24
        doReset();
        checkOutput("rst_tick", 32'(tick), 32'h0);
        checkOutput("rst_running", 32'(running), 32'h7);
        checkOutput("rst_done", 32'(done), 32'h0);
        runTo(7);
        checkOutput("fr_e7", 32'(tick), 32'h0);
        runTo(8);
        checkOutput("fr_e8", 32'(tick), 32'h7);
        runTo(9);
        checkOutput("fr_e9_width", 32'(tick), 32'h0);
        runTo(24);
        checkOutput("fr_e24", 32'(tick), 32'h7);
        for (int i = 0; i < NUM_CH; i++) checkOutput("fr_count", 32'(pulses[i]), 32'd3);
        checkOutput("fr_running", 32'(running), 32'h7);

        // One-shot: ch1 loaded period 3 on edge 10, counts down on 12/16/20, fires on 24
        doReset();
        cfgAt(10, 2'b01, 2'd1, 4'd3, 1'b1);
        runTo(16);
        checkOutput("os_e16", 32'(tick), 32'h5);
        runTo(24);
        checkOutput("os_e24", 32'(tick), 32'h7);
        runTo(25);
        checkOutput("os_done", 32'(done), 32'h2);
        checkOutput("os_running", 32'(running), 32'h5);
        runTo(48);
        checkOutput("os_e48", 32'(tick), 32'h5);
        checkOutput("os_cnt_ch0", 32'(pulses[0]), 32'd6);
        checkOutput("os_cnt_ch1", 32'(pulses[1]), 32'd2);
        checkOutput("os_cnt_ch2", 32'(pulses[2]), 32'd6);

        // Pause over edges 11..30 pushes the edge-16 tick out to edge 36
        doReset();
        runTo(10);
        pause = 1'b1;
        clearPulses();
        runTo(30);
        pause = 1'b0;
        checkOutput("pz_quiet", 32'(pulses[0] + pulses[1] + pulses[2]), 32'd0);
        runTo(35);
        checkOutput("pz_e35", 32'(tick), 32'h0);
        runTo(36);
        checkOutput("pz_e36", 32'(tick), 32'h7);
        runTo(44);
        checkOutput("pz_e44", 32'(tick), 32'h7);
        // Pause rises while the edge-44 tick is high; it still drops after one cycle
        pause = 1'b1;
        clearPulses();
        clkCycle();
        checkOutput("pz_inflight", 32'(tick), 32'h0);
        // Paused over edges 45..54 with steps on 47, 49, 51: 7 frozen edges, tick 52 -> 59
        for (int s = 46; s <= 50; s += 2) begin
            runTo(s);
            step = 1'b1;
            clkCycle();
            step = 1'b0;
        end
        runTo(54);
        pause = 1'b0;
        runTo(58);
        checkOutput("st_quiet", 32'(pulses[0] + pulses[1] + pulses[2]), 32'd0);
        checkOutput("st_e58", 32'(tick), 32'h0);
        runTo(59);
        checkOutput("st_e59", 32'(tick), 32'h7);
        // step without pause has no effect: next tick still 8 edges later
        step = 1'b1;
        runTo(62);
        step = 1'b0;
        runTo(66);
        checkOutput("st_e66", 32'(tick), 32'h0);
        runTo(67);
        checkOutput("st_e67", 32'(tick), 32'h7);

        // Stop ch2 on edge 9 with cnt=1, resume on edge 21 -> tick on 28, then 36
        doReset();
        runTo(8);
        checkOutput("sr_e8", 32'(tick), 32'h7);
        cfgAt(9, 2'b10, 2'd2, '0, 1'b0);
        checkOutput("sr_stopped", 32'(running), 32'h3);
        cfgAt(21, 2'b11, 2'd2, '0, 1'b0);
        checkOutput("sr_resumed", 32'(running), 32'h7);
        runTo(27);
        checkOutput("sr_cnt_ch2", 32'(pulses[2]), 32'd1);
        runTo(28);
        checkOutput("sr_e28", 32'(tick), 32'h4);
        runTo(32);
        checkOutput("sr_e32", 32'(tick), 32'h3);
        // ch1 one-shot period 2 loaded on edge 33: fires on 44, resumed on 46 reloads 2 -> 56
        cfgAt(33, 2'b01, 2'd1, 4'd2, 1'b1);
        runTo(36);
        checkOutput("sr_e36", 32'(tick), 32'h4);
        runTo(44);
        checkOutput("sr_e44", 32'(tick), 32'h6);
        checkOutput("sr_done44", 32'(done), 32'h2);
        cfgAt(46, 2'b11, 2'd1, '0, 1'b0);
        checkOutput("sr_run46", 32'(running), 32'h7);
        checkOutput("sr_done46", 32'(done), 32'h0);
        runTo(48);
        checkOutput("sr_e48", 32'(tick), 32'h1);
        runTo(56);
        checkOutput("sr_e56", 32'(tick), 32'h3);
        checkOutput("sr_done56", 32'(done), 32'h2);

        // LOAD ch0 in the base cycle where its cnt is 0: no tick on 8, new period 2 -> 20, 32
        doReset();
        cfgAt(8, 2'b01, 2'd0, 4'd2, 1'b0);
        checkOutput("bd_e8", 32'(tick), 32'h6);
        runTo(16);
        checkOutput("bd_e16", 32'(tick), 32'h6);
        runTo(20);
        checkOutput("bd_e20", 32'(tick), 32'h1);
        // Out-of-range channel 3 is ignored for both LOAD and STOP
        cfgAt(22, 2'b01, 2'd3, 4'd0, 1'b1);
        cfgAt(23, 2'b10, 2'd3, '0, 1'b0);
        checkOutput("bd_ch3_running", 32'(running), 32'h7);
        runTo(24);
        checkOutput("bd_e24", 32'(tick), 32'h6);
        // ch2 one-shot period 0 on edge 26 fires on 28 and parks in DONE
        cfgAt(26, 2'b01, 2'd2, 4'd0, 1'b1);
        runTo(28);
        checkOutput("bd_e28", 32'(tick), 32'h4);
        runTo(32);
        checkOutput("bd_e32", 32'(tick), 32'h3);
        checkOutput("bd_done32", 32'(done), 32'h4);
        checkOutput("bd_run32", 32'(running), 32'h3);
        // Asynchronous reset while tick is high, well before the next edge
        #2;
        reset = 1'b1;
        #1;
        checkOutput("ar_tick", 32'(tick), 32'h0);
        checkOutput("ar_running", 32'(running), 32'h7);
        checkOutput("ar_done", 32'(done), 32'h0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
